// File: rtl/axi4_pkg.sv
// -----------------------------------------------------------------------------
// axi4_pkg
//   Shared types and constants for the two-master AXI4 write-channel arbiter.
//   - axi_wr_state_e : arbiter burst state (IDLE / ADDR / DATA / RESP)
//   - OKAY/EXOKAY/SLVERR/DECERR : AXI4 BRESP encodings
//   - onehot2_to_idx : converts a 2-bit one-hot grant to a master index
// -----------------------------------------------------------------------------
package axi4_pkg;

  // One burst walks IDLE -> ADDR -> DATA -> RESP -> IDLE.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } axi_wr_state_e;

  // AXI4 write response codes.
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] EXOKAY = 2'b01;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  // Beat counter width: AWLEN is 8 bits, so 256 beats max.
  localparam int unsigned BEAT_CNT_W = 8;

  // Grant is only ever 2'b01 or 2'b10 while a burst is owned; bit 1 alone
  // identifies the owner.
  function automatic logic onehot2_to_idx(input logic [1:0] oh);
    return oh[1];
  endfunction

endpackage : axi4_pkg

// File: rtl/rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
//   Two-way round-robin picker, purely combinational.
//   Ports:
//     req_i        in  2  request vector (bit i = master i)
//     last_grant_i in  1  index of the master granted most recently
//     gnt_o        out 2  one-hot winner (0 when no request)
//   On a tie the master that was NOT granted last wins.
// -----------------------------------------------------------------------------
module rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  output logic [1:0] gnt_o
);

  // NOTE: every signal driven from always_comb gets a default first so no
  // path leaves it unassigned; an unassigned path would infer a latch.
  always_comb begin
    gnt_o = 2'b00;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = last_grant_i ? 2'b01 : 2'b10;
      default: gnt_o = 2'b00;
    endcase
  end

endmodule : rr_arb2

// File: rtl/axi4_write_arbiter.sv
// -----------------------------------------------------------------------------
// axi4_write_arbiter
//   Shares one AXI4 write slave between two masters. A round-robin pick is made
//   on AW requests while idle; the winner then owns the AW, W and B channels
//   until its B handshake completes. A burst-length checker pulses prot_err
//   when WLAST does not line up with the latched AWLEN.
//
//   Parameters: ADDR_W (address width), DATA_W (write data width)
//   Ports (master i uses slice [i*W +: W]):
//     ACLK, ARESETn                 clock, async active-low reset
//     m_aw{addr,len,valid,ready}    master AW channels
//     m_w{data,valid,last,ready}    master W channels
//     m_b{valid,ready,resp}         master B channels
//     s_aw*, s_w*, s_b*             single slave port
//     grant    one-hot owner (0 when idle)
//     busy     burst in progress
//     prot_err one-cycle pulse, cycle after a WLAST/AWLEN mismatch handshake
//
//   All channel forwarding is combinational from the registered state/grant,
//   so W beats pass at full throughput with no added latency.
// -----------------------------------------------------------------------------
module axi4_write_arbiter
  import axi4_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,

  // Master AW
  input  logic [2*ADDR_W-1:0]   m_awaddr,
  input  logic [15:0]           m_awlen,
  input  logic [1:0]            m_awvalid,
  output logic [1:0]            m_awready,
  // Master W
  input  logic [2*DATA_W-1:0]   m_wdata,
  input  logic [1:0]            m_wvalid,
  input  logic [1:0]            m_wlast,
  output logic [1:0]            m_wready,
  // Master B
  output logic [1:0]            m_bvalid,
  input  logic [1:0]            m_bready,
  output logic [3:0]            m_bresp,

  // Slave AW
  output logic [ADDR_W-1:0]     s_awaddr,
  output logic [7:0]            s_awlen,
  output logic                  s_awvalid,
  input  logic                  s_awready,
  // Slave W
  output logic [DATA_W-1:0]     s_wdata,
  output logic                  s_wvalid,
  output logic                  s_wlast,
  input  logic                  s_wready,
  // Slave B
  input  logic                  s_bvalid,
  output logic                  s_bready,
  input  logic [1:0]            s_bresp,

  // Status
  output logic [1:0]            grant,
  output logic                  busy,
  output logic                  prot_err
);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  axi_wr_state_e             state_q,      state_d;
  logic [1:0]                grant_q,      grant_d;
  logic                      last_grant_q, last_grant_d;
  logic [BEAT_CNT_W-1:0]     beat_cnt_q,   beat_cnt_d;
  logic [7:0]                awlen_q,      awlen_d;
  logic                      prot_err_q,   prot_err_d;

  logic [1:0]                arb_gnt;
  logic                      g_idx;

  // Selected master's channel signals.
  logic [ADDR_W-1:0]         sel_awaddr;
  logic [7:0]                sel_awlen;
  logic                      sel_awvalid;
  logic [DATA_W-1:0]         sel_wdata;
  logic                      sel_wvalid;
  logic                      sel_wlast;
  logic                      sel_bready;

  logic                      aw_hs;
  logic                      w_hs;
  logic                      b_hs;

  rr_arb2 u_rr_arb2 (
    .req_i        (m_awvalid),
    .last_grant_i (last_grant_q),
    .gnt_o        (arb_gnt)
  );

  assign g_idx = onehot2_to_idx(grant_q);

  assign sel_awaddr  = g_idx ? m_awaddr[2*ADDR_W-1:ADDR_W] : m_awaddr[ADDR_W-1:0];
  assign sel_awlen   = g_idx ? m_awlen[15:8]               : m_awlen[7:0];
  assign sel_awvalid = m_awvalid[g_idx];
  assign sel_wdata   = g_idx ? m_wdata[2*DATA_W-1:DATA_W]  : m_wdata[DATA_W-1:0];
  assign sel_wvalid  = m_wvalid[g_idx];
  assign sel_wlast   = m_wlast[g_idx];
  assign sel_bready  = m_bready[g_idx];

  // Handshakes are only meaningful inside their owning state.
  assign aw_hs = (state_q == ADDR) && sel_awvalid && s_awready;
  assign w_hs  = (state_q == DATA) && sel_wvalid  && s_wready;
  assign b_hs  = (state_q == RESP) && s_bvalid    && sel_bready;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    beat_cnt_d   = beat_cnt_q;
    awlen_d      = awlen_q;
    prot_err_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (|m_awvalid) begin
          grant_d = arb_gnt;
          state_d = ADDR;
        end
      end

      ADDR: begin
        if (aw_hs) begin
          beat_cnt_d = '0;
          awlen_d    = sel_awlen;
          state_d    = DATA;
        end
      end

      DATA: begin
        if (w_hs) begin
          // Past the last expected beat the counter may wrap; it only feeds
          // the mismatch flag, and the burst still closes on WLAST.
          beat_cnt_d = beat_cnt_q + 1'b1;
          if (sel_wlast) begin
            state_d = RESP;
            if (beat_cnt_q != awlen_q) prot_err_d = 1'b1;
          end else if (beat_cnt_q == awlen_q) begin
            // Final beat per AWLEN arrived without WLAST: flag it and keep
            // forwarding until the master does raise WLAST.
            prot_err_d = 1'b1;
          end
        end
      end

      RESP: begin
        if (b_hs) begin
          last_grant_d = g_idx;
          grant_d      = 2'b00;
          state_d      = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q      <= IDLE;
      grant_q      <= 2'b00;
      last_grant_q <= 1'b1;   // M0 wins the first tie after reset
      beat_cnt_q   <= '0;
      awlen_q      <= '0;
      prot_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      beat_cnt_q   <= beat_cnt_d;
      awlen_q      <= awlen_d;
      prot_err_q   <= prot_err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Channel forwarding: everything idles at 0 unless the current state owns
  // the channel. Since state resets asynchronously to IDLE, all outputs drop
  // in the same cycle reset is asserted.
  // ---------------------------------------------------------------------------
  always_comb begin
    m_awready = 2'b00;
    m_wready  = 2'b00;
    m_bvalid  = 2'b00;
    m_bresp   = 4'b0000;
    s_awaddr  = '0;
    s_awlen   = '0;
    s_awvalid = 1'b0;
    s_wdata   = '0;
    s_wvalid  = 1'b0;
    s_wlast   = 1'b0;
    s_bready  = 1'b0;

    case (state_q)
      ADDR: begin
        s_awaddr         = sel_awaddr;
        s_awlen          = sel_awlen;
        s_awvalid        = sel_awvalid;
        m_awready[g_idx] = s_awready;
      end

      DATA: begin
        s_wdata         = sel_wdata;
        s_wvalid        = sel_wvalid;
        s_wlast         = sel_wlast;
        m_wready[g_idx] = s_wready;
      end

      RESP: begin
        m_bvalid[g_idx] = s_bvalid;
        if (g_idx) m_bresp[3:2] = s_bresp;
        else       m_bresp[1:0] = s_bresp;
        s_bready        = sel_bready;
      end

      default: ;
    endcase
  end

  assign grant    = grant_q;
  assign busy     = (state_q != IDLE);
  assign prot_err = prot_err_q;

endmodule : axi4_write_arbiter
